// File: rtl/drum_pipe_mult.sv
// drum_pipe_mult: parametrised DRUM approximate multiplier with a 3-stage
// valid/ready pipeline. S1 reduces each operand to a K-bit mantissa plus a
// shift; S2 multiplies the mantissas; S3 shifts and applies the sign.
module drum_pipe_mult #(
    parameter int WIDTH  = 16,
    parameter int K      = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_r
);

    localparam int OW = 2 * WIDTH;
    localparam int SW = $clog2(2 * WIDTH);
    localparam int PW = 2 * K;

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OW-1:0]    ONE_OW = {{(OW-1){1'b0}}, 1'b1};
    localparam logic [K-1:0]     ONE_K  = {{(K-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [K-1:0]  mm;
        logic [SW-1:0] p;
    } drum_red_t;

    // Absolute value in signed mode; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (SIGNED && v[WIDTH-1]) begin
            m = ~v + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Leading-one detect, then keep K bits below it with the LSB forced to 1
    // (unbiases the truncation). Small values pass through exactly.
    function automatic drum_red_t drum_reduce(input logic [WIDTH-1:0] x);
        drum_red_t r;
        int        lead;
        lead = -1;
        for (int i = 0; i < WIDTH; i++) begin
            lead = x[i] ? i : lead;
        end
        if (lead >= K) begin
            r.p  = SW'(lead - K + 1);
            r.mm = K'(x >> (lead - K + 1)) | ONE_K;
        end else begin
            r.p  = '0;
            r.mm = x[K-1:0];
        end
        return r;
    endfunction

    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    drum_red_t        red_a_s, red_b_s;
    logic [K-1:0]     s1_mma_d, s1_mmb_d;
    logic [SW-1:0]    s1_p_d;
    logic             s1_sign_d;

    logic             s1_valid_q;
    logic [K-1:0]     s1_mma_q, s1_mmb_q;
    logic [SW-1:0]    s1_p_q;
    logic             s1_sign_q;

    logic [PW-1:0]    s2_prod_d;
    logic             s2_valid_q;
    logic [PW-1:0]    s2_prod_q;
    logic [SW-1:0]    s2_p_q;
    logic             s2_sign_q;

    logic [OW-1:0]    s3_mag_s, s3_out_d;
    logic             s3_valid_q;
    logic [OW-1:0]    s3_out_q;

    logic             ready1_s, ready2_s, ready3_s;

    // Ready chain: a stage can load when empty or when it empties this cycle.
    always_comb begin
        ready3_s = !s3_valid_q || out_ready;
        ready2_s = !s2_valid_q || ready3_s;
        ready1_s = !s1_valid_q || ready2_s;
    end

    assign in_ready  = ready1_s;
    assign out_valid = s3_valid_q;
    assign out_r     = s3_out_q;

    // S1 next-state: operand reduction and result sign.
    always_comb begin
        mag_a_s  = magnitude(in_a);
        mag_b_s  = magnitude(in_b);
        red_a_s  = drum_reduce(mag_a_s);
        red_b_s  = drum_reduce(mag_b_s);
        s1_mma_d = red_a_s.mm;
        s1_mmb_d = red_b_s.mm;
        s1_p_d   = red_a_s.p + red_b_s.p;
        if (SIGNED) begin
            s1_sign_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end else begin
            s1_sign_d = 1'b0;
        end
    end

    // S1 register: accept an operand pair when the stage can load.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mma_q   <= '0;
            s1_mmb_q   <= '0;
            s1_p_q     <= '0;
            s1_sign_q  <= 1'b0;
        end else if (ready1_s) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_mma_q  <= s1_mma_d;
                s1_mmb_q  <= s1_mmb_d;
                s1_p_q    <= s1_p_d;
                s1_sign_q <= s1_sign_d;
            end
        end
    end

    // S2 next-state: full-width K x K mantissa product.
    always_comb begin
        s2_prod_d = {{K{1'b0}}, s1_mma_q} * {{K{1'b0}}, s1_mmb_q};
    end

    // S2 register: product, total shift and sign move forward together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_p_q     <= '0;
            s2_sign_q  <= 1'b0;
        end else if (ready2_s) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= s2_prod_d;
                s2_p_q    <= s1_p_q;
                s2_sign_q <= s1_sign_q;
            end
        end
    end

    // S3 next-state: barrel shift, then negate; a zero magnitude stays zero.
    always_comb begin
        s3_mag_s = OW'(s2_prod_q) << s2_p_q;
        if (s2_sign_q && (s3_mag_s != '0)) begin
            s3_out_d = ~s3_mag_s + ONE_OW;
        end else begin
            s3_out_d = s3_mag_s;
        end
    end

    // S3 register: the presented result, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q <= 1'b0;
            s3_out_q   <= '0;
        end else if (ready3_s) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_out_q <= s3_out_d;
            end
        end
    end

endmodule
